// File: rtl/fifo_stream_pkg.sv
// Shared constants and helpers for the FIFO-to-stream reader.
// The output buffer depth also bounds how many reads may be outstanding.
package fifo_stream_pkg;

  localparam int BUF_DEPTH         = 3;
  localparam int OCC_WIDTH         = 2;
  localparam int DEFAULT_LEN_WIDTH = 16;

  typedef logic [OCC_WIDTH-1:0] occ_t;

  // True when a new read still has a guaranteed slot in the output buffer,
  // counting both buffered beats and the read already in flight.
  function automatic logic canIssue(input occ_t occ, input logic infl);
    return ({1'b0, occ} + {2'b00, infl}) < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/stream_out_buf.sv
// Small in-order output buffer: push at the tail, pop at the head,
// head entry always sits in slot 0 so the stream data comes straight
// from a register.
module stream_out_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_pushData,
  input  logic                  i_pop,
  output occ_t                  o_occ,
  output logic [DATA_WIDTH-1:0] o_headData
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  occ_t                  r_occ;

  logic [DATA_WIDTH-1:0] w_memNext [BUF_DEPTH];
  occ_t                  w_occNext;
  occ_t                  w_wrIdx;
  logic                  w_pop;
  logic                  w_push;

  // A pop on an empty buffer or a push into a full one without a pop is ignored.
  assign w_pop   = i_pop & (r_occ != '0);
  assign w_push  = i_push & ((r_occ != occ_t'(BUF_DEPTH)) | w_pop);
  assign w_wrIdx = r_occ - occ_t'(w_pop);

  // Shift toward the head on pop, then write the new tail slot on push.
  always_comb begin
    w_memNext = r_mem;
    if (w_pop) begin
      for (int i = 0; i < BUF_DEPTH - 1; i++) begin
        w_memNext[i] = r_mem[i + 1];
      end
      w_memNext[BUF_DEPTH-1] = '0;
    end
    if (w_push) begin
      w_memNext[w_wrIdx] = i_pushData;
    end
    w_occNext = r_occ + occ_t'(w_push) - occ_t'(w_pop);
  end

  // Buffer storage and occupancy; reset empties the buffer and zeroes the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_occ <= '0;
    end else begin
      r_mem <= w_memNext;
      r_occ <= w_occNext;
    end
  end

  assign o_occ      = r_occ;
  assign o_headData = r_mem[0];

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a standard (non-showahead) FIFO and presents the words as a
// valid/ready stream with optional fixed-length framing via TLAST.
// Reads are only issued when the output buffer can absorb them, so the
// read enable never depends on the sink's ready.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
)
(
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  ENABLE,
  input  logic [LEN_WIDTH-1:0]  PKT_LEN,
  input  logic                  FIFO_EMPTY,
  output logic                  FIFO_RE,
  input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
  input  logic                  FIFO_VALID,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic [DATA_WIDTH-1:0] M_TDATA,
  output logic                  M_TLAST,
  output logic                  BUSY,
  output logic                  ERR_UNEXP
);

  logic                 r_infl;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [LEN_WIDTH-1:0] r_lenQ;
  logic                 r_errUnexp;

  occ_t                  w_occ;
  logic [DATA_WIDTH-1:0] w_headData;
  logic                  w_fifoRe;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_last;

  // Read enable is held low while in reset so nothing is requested that
  // the cleared in-flight flag could not account for.
  assign w_fifoRe = RSTN & ENABLE & ~FIFO_EMPTY & canIssue(w_occ, r_infl);
  assign w_push   = FIFO_VALID & r_infl;
  assign w_valid  = (w_occ != '0);
  assign w_pop    = w_valid & M_TREADY;
  assign w_last   = (r_lenQ != '0) & (r_cnt == r_lenQ - LEN_WIDTH'(1));

  stream_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outBuf (
    .clk        (CLK),
    .rst_n      (RSTN),
    .i_push     (w_push),
    .i_pushData (FIFO_DOUT),
    .i_pop      (w_pop),
    .o_occ      (w_occ),
    .o_headData (w_headData)
  );

  // Remember whether a read was issued last cycle so the returning data is expected.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_infl <= 1'b0;
    end else begin
      r_infl <= w_fifoRe;
    end
  end

  // Packet framing: length is sampled between packets and frozen mid-packet.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt  <= '0;
      r_lenQ <= '0;
    end else begin
      if (r_cnt == '0) begin
        r_lenQ <= PKT_LEN;
      end
      if (w_pop && (r_lenQ != '0)) begin
        r_cnt <= w_last ? '0 : r_cnt + LEN_WIDTH'(1);
      end
    end
  end

  // Sticky flag for read data that arrives without a matching request.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_errUnexp <= 1'b0;
    end else if (FIFO_VALID && !r_infl) begin
      r_errUnexp <= 1'b1;
    end
  end

  assign FIFO_RE   = w_fifoRe;
  assign M_TVALID  = w_valid;
  assign M_TDATA   = w_headData;
  assign M_TLAST   = w_last;
  assign BUSY      = w_valid | r_infl;
  assign ERR_UNEXP = r_errUnexp;

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning FIFO/stream data width.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, meaning packet-length field width.
REQ-003 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port RSTN  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ENABLE  input  1  permits issuing new FIFO reads.
REQ-006 SHALL have port PKT_LEN  input  LEN_WIDTH  beats per packet; 0 means unframed.
REQ-007 SHALL have port FIFO_EMPTY  input  1  upstream standard (non-showahead) FIFO empty flag.
REQ-008 SHALL have port FIFO_RE  output  1  FIFO read enable.
REQ-009 SHALL have port FIFO_DOUT  input  DATA_WIDTH  FIFO read data.
REQ-010 SHALL have port FIFO_VALID  input  1  FIFO read data valid, one cycle after an accepted read.
REQ-011 SHALL have port M_TVALID  output  1  stream beat valid.
REQ-012 SHALL have port M_TREADY  input  1  stream sink ready.
REQ-013 SHALL have port M_TDATA  output  DATA_WIDTH  stream data.
REQ-014 SHALL have port M_TLAST  output  1  last beat of packet.
REQ-015 SHALL have port BUSY  output  1  beat buffered or read in flight.
REQ-016 SHALL have port ERR_UNEXP  output  1  sticky: FIFO_VALID seen with no read in flight.

Function
REQ-017 SHALL hold a 3-entry in-order output buffer (occupancy occ 0..3) and a 1-bit in-flight flag infl = FIFO_RE of previous cycle.
REQ-018 SHALL drive FIFO_RE = ENABLE & ~FIFO_EMPTY & (occ + infl < 3), from registered state only (no combinational path from M_TREADY).
REQ-019 SHALL push FIFO_DOUT into the buffer tail on every cycle FIFO_VALID=1 and infl=1.
REQ-020 SHALL drive M_TVALID = (occ != 0) and M_TDATA = buffer head.
REQ-021 SHALL pop the head on M_TVALID & M_TREADY; simultaneous push and pop leaves occ unchanged.
REQ-022 SHALL hold M_TDATA/M_TLAST stable while M_TVALID=1 and M_TREADY=0.
REQ-023 SHALL sustain one beat per cycle when FIFO non-empty and M_TREADY held high; first-beat latency FIFO_RE -> M_TVALID = 2 cycles.
REQ-024 SHALL keep a LEN_WIDTH beat counter cnt, incrementing on each handshake, returning to 0 after the beat carrying M_TLAST.
REQ-025 SHALL latch PKT_LEN into len_q while cnt==0; len_q frozen while cnt!=0.
REQ-026 SHALL drive M_TLAST = (len_q != 0) & (cnt == len_q - 1); len_q==1 gives TLAST on every beat; len_q==0 keeps TLAST low and cnt at 0.
REQ-027 SHALL, on ENABLE deassertion, issue no new reads but still capture the in-flight beat and drain the buffer.
REQ-028 SHALL set ERR_UNEXP on FIFO_VALID=1 with infl=0, drop that data, and hold ERR_UNEXP until reset.
REQ-029 SHALL drive BUSY = (occ != 0) | infl.

Reset
REQ-030 SHALL, on RSTN low, asynchronously clear occ, infl, cnt, len_q, ERR_UNEXP; FIFO_RE, M_TVALID, M_TLAST, BUSY low; M_TDATA 0.
REQ-031 SHALL discard buffered and in-flight data on reset mid-packet; first beat after release starts a new packet (cnt=0).
REQ-032 SHALL deassert reset synchronously externally; no internal synchronizer.

Structure
REQ-033 SHALL take LEN_WIDTH default and buffer depth constant (3) from shared package fifo_stream_pkg.
REQ-034 SHALL implement the 3-entry buffer as sub-module stream_out_buf (push/pop/occupancy, head data).

Verification
REQ-035 SHALL cover: FIFO preloaded 8 words 0x10..0x17, PKT_LEN=4, M_TREADY=1 -> 8 consecutive beats, TLAST on 0x13 and 0x17, first M_TVALID 2 cycles after first FIFO_RE.
REQ-036 SHALL cover: M_TREADY=0 for 10 cycles with FIFO full -> exactly 3 FIFO_RE pulses, occ=3, M_TDATA stable, no data loss after release.
REQ-037 SHALL cover: M_TREADY toggling 1010..., PKT_LEN=3, 9 words -> in-order data, TLAST on beats 3,6,9.
REQ-038 SHALL cover: ENABLE dropped during streaming -> FIFO_RE low next cycle, buffered beats drain, BUSY falls after last handshake.
REQ-039 SHALL cover: FIFO_VALID forced with no prior FIFO_RE -> ERR_UNEXP=1 sticky, no M_TVALID from it.
REQ-040 SHALL cover: RSTN asserted mid-packet (cnt=2, occ=2) -> all outputs 0 immediately; after release, PKT_LEN=2 packet TLAST on its 2nd beat.
